shift_registers_var: RTL and testbench

Parametrised, multi-bit, variable-tap shift register. It is the next generation of the fixed single-bit, fixed-depth SRL template in the synth_xilinx_srl suite. It adds data width, a runtime-selectable tap (SRLC32E A-port style), a fill-level tracker with per-tap valid, and a synchronous flush. It sits in datapath delay-matching and is the top of its SRL-mapping test case.

---
 rtl/shift_registers_var_pkg.sv | 20 ++
 rtl/shift_registers_var_fill_ctr.sv | 50 +++++
 rtl/shift_registers_var.sv | 90 +++++++++
 tb/tb_shift_registers_var.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_registers_var_pkg.sv
// Shared constants and helpers for the variable-tap shift register.
// Optional feature macro: SHREG_CASCADE_EN (adds the SQ cascade output).
package shreg_pkg;

  // Default geometry: one SRLC32E-sized column of bytes.
  localparam int SHREG_WIDTH_DEF = 8;
  localparam int SHREG_DEPTH_DEF = 32;

  // Tap-address width for a given depth; never narrower than one bit so the
  // A port always exists, even for degenerate depths.
  function automatic int shreg_aw(input int depth);
    int w;
    w = $clog2(depth);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : shreg_pkg

// File: rtl/shift_registers_var_fill_ctr.sv
// Fill-level tracker for the variable-tap shift register.
// Counts enabled shifts since reset or flush, saturating at DEPTH, and derives
// the per-tap valid flag and the full flag from that count.
// Optional feature macro: SHREG_CASCADE_EN (does not affect this block).
module shreg_fill_ctr
  import shreg_pkg::*;
#(
  parameter int DEPTH = SHREG_DEPTH_DEF,
  parameter int AW    = shreg_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  input  logic [AW-1:0] A,
  output logic          SO_VALID,
  output logic          FULL
);

  // One extra bit so the count can represent DEPTH itself.
  localparam logic [AW:0] FILL_MAX = (AW + 1)'(DEPTH);

  logic [AW:0] fill;
  logic [AW:0] fill_next;

  // Next fill level: flush wins over shift, and the count sticks at DEPTH.
  always_comb begin
    fill_next = fill;
    if (clr) begin
      fill_next = '0;
    end else if (inc && (fill != FILL_MAX)) begin
      fill_next = fill + 1'b1;
    end
  end

  // Fill register; reset is asynchronous so outputs clear without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
    end else begin
      fill <= fill_next;
    end
  end

  // Tap d is valid once more than d words have entered. Taps at or beyond
  // DEPTH can never satisfy this because fill never exceeds DEPTH.
  assign SO_VALID = ({1'b0, A} < fill);
  assign FULL     = (fill == FILL_MAX);

endmodule : shreg_fill_ctr

// File: rtl/shift_registers_var.sv
// Parametrised multi-bit shift register with a runtime tap select, a fill
// tracker giving per-tap valid and full, and a synchronous flush of the fill
// level. Stage contents survive a flush; only reset clears them.
// Optional feature macro: SHREG_CASCADE_EN (adds SQ = oldest stage).
module shift_registers_var
  import shreg_pkg::*;
#(
  parameter int WIDTH = SHREG_WIDTH_DEF,
  parameter int DEPTH = SHREG_DEPTH_DEF,
  parameter int AW    = shreg_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clken,
  input  logic             clr,
  input  logic [WIDTH-1:0] SI,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] SO,
  output logic             SO_VALID,
  output logic             FULL
`ifdef SHREG_CASCADE_EN
  ,
  output logic [WIDTH-1:0] SQ
`endif
);

  // Stage array: index 0 is the newest word, DEPTH-1 the oldest.
  logic [WIDTH-1:0] shreg [DEPTH];

  // A flush cycle suppresses the shift and drops SI.
  logic shift;
  assign shift = clken & ~clr;

  // One register per stage; each block owns exactly one array element.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] q;

    if (gi == 0) begin : g_head
      // Head stage captures the serial input on every shift.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (shift) begin
          q <= SI;
        end
      end
    end else begin : g_body
      // Body stages take the word from the next-newer stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (shift) begin
          q <= shreg[gi-1];
        end
      end
    end

    assign shreg[gi] = q;
  end

  // Tap mux as an AND-OR select; an out-of-range A matches no stage and
  // therefore reads as zero.
  always_comb begin
    SO = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, A} == (AW + 1)'(i)) begin
        SO = shreg[i];
      end
    end
  end

`ifdef SHREG_CASCADE_EN
  // Cascade output: the oldest stage regardless of the tap select.
  assign SQ = shreg[DEPTH-1];
`endif

  shreg_fill_ctr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fill_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (clken),
    .clr      (clr),
    .A        (A),
    .SO_VALID (SO_VALID),
    .FULL     (FULL)
  );

endmodule : shift_registers_var

// File: tb/tb_shift_registers_var.sv
// Directed bench for shift_registers_var: one 8x32 instance and one 8x24
// instance (non-power-of-two depth) share clock, reset and inputs.
// Optional feature macro: SHREG_CASCADE_EN (enables SQ checks).
module tb_shift_registers_var;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clken = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] si = '0;
  logic [4:0] a = '0;

  logic [7:0] so32, so24;
  logic       valid32, valid24, full32, full24;
`ifdef SHREG_CASCADE_EN
  logic [7:0] sq32, sq24;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_registers_var #(.WIDTH(8), .DEPTH(32)) dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clken    (clken),
    .clr      (clr),
    .SI       (si),
    .A        (a),
    .SO       (so32),
    .SO_VALID (valid32),
    .FULL     (full32)
`ifdef SHREG_CASCADE_EN
    ,
    .SQ       (sq32)
`endif
  );

  shift_registers_var #(.WIDTH(8), .DEPTH(24)) dut24 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clken    (clken),
    .clr      (clr),
    .SI       (si),
    .A        (a),
    .SO       (so24),
    .SO_VALID (valid24),
    .FULL     (full24)
`ifdef SHREG_CASCADE_EN
    ,
    .SQ       (sq24)
`endif
  );

  typedef struct {
    bit         tick;
    bit         en;
    bit         fl;
    logic [7:0] din;
    logic [4:0] tap;
    logic [7:0] so;
    bit         valid;
    bit         full;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input bit tick, input bit en, input bit fl,
                              input logic [7:0] din, input logic [4:0] tap,
                              input logic [7:0] so, input bit valid, input bit full);
    vec_t v;
    v.tick = tick; v.en = en; v.fl = fl; v.din = din; v.tap = tap;
    v.so = so; v.valid = valid; v.full = full;
    tbl.push_back(v);
  endfunction

  // Drive inputs at the falling edge, optionally take one rising edge, then
  // sample 1 time unit later.
  task automatic step(input bit tick, input bit en, input bit fl,
                      input logic [7:0] din, input logic [4:0] tap);
    @(negedge clk);
    clken = en; clr = fl; si = din; a = tap;
    if (tick) begin
      @(posedge clk);
    end
    #1;
  endtask

  // Asynchronous reset pulse that starts and ends while clk is low.
  task automatic pulse_reset();
    @(negedge clk);
    clken = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_so", so32, 8'h00);
    chk("rst_valid", {7'd0, valid32}, 8'h00);
    chk("rst_full", {7'd0, full32}, 8'h00);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Enable gating and flush priority, applied from a freshly reset state.
    add(1, 1, 0, 8'hA5, 0, 8'hA5, 1, 0);
    for (int k = 0; k < 10; k++) add(1, 0, 0, 8'h3C + 8'(k), 0, 8'hA5, 1, 0);
    add(0, 0, 0, 8'h00, 1, 8'h00, 0, 0);
    for (int k = 1; k <= 19; k++) add(1, 1, 0, 8'h40 + 8'(k), 0, 8'h40 + 8'(k), 1, 0);
    add(0, 0, 0, 8'h00, 19, 8'hA5, 1, 0);
    add(0, 0, 0, 8'h00, 20, 8'h00, 0, 0);
    add(1, 1, 1, 8'hFF, 0, 8'h53, 0, 0);
    for (int t = 0; t < 32; t += 7) add(0, 0, 0, 8'h00, 5'(t), (t == 0) ? 8'h53 : (t == 7) ? 8'h4C : (t == 14) ? 8'h45 : 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 19, 8'hA5, 0, 0);
    add(1, 1, 0, 8'h77, 0, 8'h77, 1, 0);
    add(0, 0, 0, 8'h00, 1, 8'h53, 0, 0);
    add(1, 0, 1, 8'h99, 0, 8'h77, 0, 0);

    // Power-on reset state.
    #2;
    chk("por_so", so32, 8'h00);
    chk("por_valid", {7'd0, valid32}, 8'h00);
    chk("por_full", {7'd0, full32}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-run: five words in, asynchronous reset, then restart.
    for (int k = 1; k <= 5; k++) step(1, 1, 0, 8'h10 + 8'(k), 0);
    step(0, 0, 0, 8'h00, 4);
    chk("mid_pre_so", so32, 8'h11);
    chk("mid_pre_valid", {7'd0, valid32}, 8'h01);
    a = 5'd4;
    pulse_reset();
    step(1, 1, 0, 8'h3C, 0);
    chk("mid_post_so0", so32, 8'h3C);
    chk("mid_post_v0", {7'd0, valid32}, 8'h01);
    step(0, 0, 0, 8'h00, 1);
    chk("mid_post_so1", so32, 8'h00);
    chk("mid_post_v1", {7'd0, valid32}, 8'h00);

    // Basic shift of 0x01..0x20; FULL must rise exactly on the 32nd edge.
    pulse_reset();
    for (int k = 1; k <= 32; k++) begin
      step(1, 1, 0, 8'(k), 0);
      chk($sformatf("basic_so_e%0d", k), so32, 8'(k));
      chk($sformatf("basic_full_e%0d", k), {7'd0, full32}, {7'd0, (k == 32)});
    end
    for (int t = 0; t < 32; t += 5) begin
      step(0, 0, 0, 8'h00, 5'(t));
      chk($sformatf("basic_so_a%0d", t), so32, 8'h20 - 8'(t));
      chk($sformatf("basic_valid_a%0d", t), {7'd0, valid32}, 8'h01);
`ifdef SHREG_CASCADE_EN
      chk($sformatf("cascade_sq_a%0d", t), sq32, 8'h01);
`endif
    end
    step(0, 0, 0, 8'h00, 31);
    chk("basic_so_a31", so32, 8'h01);
`ifdef SHREG_CASCADE_EN
    chk("cascade_sq_a31", sq32, 8'h01);
`endif

    // Table: enable gating and flush priority.
    pulse_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].tick, tbl[i].en, tbl[i].fl, tbl[i].din, tbl[i].tap);
      chk($sformatf("tbl%0d_so", i), so32, tbl[i].so);
      chk($sformatf("tbl%0d_valid", i), {7'd0, valid32}, {7'd0, tbl[i].valid});
      chk($sformatf("tbl%0d_full", i), {7'd0, full32}, {7'd0, tbl[i].full});
    end

    // Saturation and out-of-range taps on the 24-deep instance.
    pulse_reset();
    for (int k = 1; k <= 40; k++) begin
      step(1, 1, 0, 8'(k), 0);
      chk($sformatf("sat_full24_e%0d", k), {7'd0, full24}, {7'd0, (k >= 24)});
    end
    step(0, 0, 0, 8'h00, 0);
    chk("sat_so24_a0", so24, 8'd40);
    step(0, 0, 0, 8'h00, 23);
    chk("sat_so24_a23", so24, 8'd17);
    chk("sat_valid24_a23", {7'd0, valid24}, 8'h01);
`ifdef SHREG_CASCADE_EN
    chk("sat_sq24", sq24, 8'd17);
`endif
    for (int t = 24; t < 32; t++) begin
      step(0, 0, 0, 8'h00, 5'(t));
      chk($sformatf("oor_so24_a%0d", t), so24, 8'h00);
      chk($sformatf("oor_valid24_a%0d", t), {7'd0, valid24}, 8'h00);
    end
    step(0, 0, 0, 8'h00, 31);
    chk("sat_so32_a31", so32, 8'd9);
    chk("sat_valid32_a31", {7'd0, valid32}, 8'h01);
    chk("sat_full32", {7'd0, full32}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_shift_registers_var
